// File: rtl/disp_vram_rslave.sv
// disp_vram_rslave: AXI4 read-channel slave returning INCR bursts from a 64-bit synchronous frame RAM.
// Build macro DISP_VRAM_PATTERN_EN swaps RAM read data for {2{word_addr ^ PAT_SEED}} and ignores host writes.
module disp_vram_rslave #(
    parameter int          MEM_AW   = 14,
    parameter logic [31:0] PAT_SEED = 32'h0000_0000
) (
    input  logic              ACLK,
    input  logic              ARST,
    input  logic [31:0]       ARADDR,
    input  logic [7:0]        ARLEN,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [63:0]       RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY,
    input  logic              MEM_WE,
    input  logic [MEM_AW-1:0] MEM_WADDR,
    input  logic [63:0]       MEM_WDATA,
    output logic              BUSY
);
    typedef enum logic {S_IDLE, S_BURST} state_t;
    state_t state, state_n;
    logic [MEM_AW-1:0] start, rd_addr;
    logic [7:0] len;
    logic [8:0] iss;
    logic rd_en, rd_last, rd_v, q_last, pop, l0, l1;
    logic [63:0] ram_q, d0, d1;
    logic [1:0] cnt;
    logic unused_addr;

    assign unused_addr = ^{ARADDR[31:MEM_AW+3], ARADDR[2:0]};
    assign pop = RVALID && RREADY;
    assign RVALID = cnt != 2'd0;
    assign RDATA = d0;
    assign RLAST = l0 && RVALID;
    assign RRESP = 2'b00;
    assign ARREADY = state == S_IDLE && !ARST;
    assign BUSY = state == S_BURST;

    // Issue one RAM read per cycle while a skid slot is guaranteed free when its data lands
    always_comb begin
        state_n = state;
        rd_en = 1'b0;
        rd_addr = state == S_IDLE ? ARADDR[MEM_AW+2:3] : start + MEM_AW'(iss);
        rd_last = state == S_IDLE ? ARLEN == 8'd0 : iss == {1'b0, len};
        if (state == S_IDLE) begin
            rd_en = ARVALID && ARREADY;
            state_n = rd_en ? S_BURST : S_IDLE;
        end else begin
            rd_en = iss <= {1'b0, len} && ({1'b0, cnt} + 3'(rd_v)) < (3'd2 + 3'(pop));
            state_n = pop && l0 ? S_IDLE : S_BURST;
        end
    end

    // Burst bookkeeping, read pipeline valid and the 2-entry output skid buffer
    always_ff @(posedge ACLK) begin
        if (ARST) begin
            state <= S_IDLE;
            start <= '0;
            len <= '0;
            iss <= '0;
            rd_v <= 1'b0;
            q_last <= 1'b0;
            cnt <= '0;
            d0 <= '0;
            d1 <= '0;
            l0 <= 1'b0;
            l1 <= 1'b0;
        end else begin
            state <= state_n;
            rd_v <= rd_en;
            q_last <= rd_last;
            if (state == S_IDLE) begin
                start <= ARADDR[MEM_AW+2:3];
                len <= ARLEN;
                iss <= 9'd1;
            end else if (rd_en) begin
                iss <= iss + 9'd1;
            end
            cnt <= cnt + 2'(rd_v) - 2'(pop);
            if (pop) begin
                d0 <= d1;
                l0 <= l1;
            end
            if (rd_v && cnt - 2'(pop) == 2'd0) begin
                d0 <= ram_q;
                l0 <= q_last;
            end else if (rd_v) begin
                d1 <= ram_q;
                l1 <= q_last;
            end
        end
    end

`ifdef DISP_VRAM_PATTERN_EN
    logic unused_wr;
    assign unused_wr = ^{MEM_WE, MEM_WADDR, MEM_WDATA};
    // Synthetic read data derived from the beat's word address
    always_ff @(posedge ACLK) begin
        if (rd_en) ram_q <= {2{32'(rd_addr) ^ PAT_SEED}};
    end
`else
    logic [63:0] mem [2**MEM_AW];
    // Read-first frame RAM: a same-cycle host write to the read word returns old data
    always_ff @(posedge ACLK) begin
        if (MEM_WE) mem[MEM_WADDR] <= MEM_WDATA;
        if (rd_en) ram_q <= mem[rd_addr];
    end
`endif
endmodule
